// File: rtl/demux_dispatch_pkg.sv
// Shared types and constants for the packet dispatch controller
// and the round-robin picker it uses.
package demux_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } dispatch_state_t;

    typedef logic [1:0] chan_t;

    localparam int   NUM_CH   = 4;
    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

endpackage

// File: rtl/demux_dispatch_ctrl_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker.
// Ports: rr_ptr (search start), en_mask (candidates) -> target, found.
module rr_pick4
    import demux_dispatch_pkg::*;
(
    input  chan_t      rr_ptr,
    input  logic [3:0] en_mask,
    output chan_t      target,
    output logic       found
);

    chan_t idx;

    // Scan from the farthest offset down so the nearest enabled
    // channel (starting at rr_ptr) is the last one to win.
    always_comb begin
        target = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = rr_ptr + chan_t'(i);
            if (en_mask[idx]) begin
                target = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: packet-level controller for a 1-to-4 demux slice.
// Ports: clk, rst_n, mode, en_mask, in_* stream, sel/out_* to the slice,
//   busy, pkt_cnt (4 x CNT_W), drop_cnt. Optional stall watchdog with
//   stall_err output when DEMUX_DISPATCH_TIMEOUT_EN is defined.
module demux_dispatch_ctrl
    import demux_dispatch_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [3:0]            en_mask,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  chan_t                 in_dest,
    input  logic                  in_last,
    output chan_t                 sel,
    output logic [DATA_W-1:0]     out_data,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic                  busy,
    output logic [4*CNT_W-1:0]    pkt_cnt,
    output logic [CNT_W-1:0]      drop_cnt
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    ,
    output logic                  stall_err
`endif
);

    dispatch_state_t state;
    chan_t           rr_ptr;
    logic            mode_q;
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    chan_t           rr_target;
    logic            rr_found;
    logic            acc;

    rr_pick4 u_pick (
        .rr_ptr  (rr_ptr),
        .en_mask (en_mask),
        .target  (rr_target),
        .found   (rr_found)
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
        assign pkt_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end

    assign out_data = in_data;
    assign busy     = (state != IDLE);
    assign acc      = in_valid && in_ready;

    always_comb begin
        out_valid = '0;
        in_ready  = 1'b0;
        unique case (state)
            ROUTE: begin
                out_valid[sel] = in_valid;
                in_ready       = out_ready[sel];
            end
            DROP:    in_ready = 1'b1;
            default: ;
        endcase
    end

`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            rr_ptr   <= '0;
            mode_q   <= MODE_ADDR;
            drop_cnt <= '0;
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
            stall_cnt <= '0;
            stall_err <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode_q <= mode;
                        if (mode == MODE_ADDR) begin
                            if (en_mask[in_dest]) begin
                                sel   <= in_dest;
                                state <= ROUTE;
                            end else begin
                                state <= DROP;
                            end
                        end else if (rr_found) begin
                            sel   <= rr_target;
                            state <= ROUTE;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                ROUTE: begin
                    if (acc && in_last) begin
                        cnt_q[sel] <= cnt_q[sel] + 1'b1;
                        if (mode_q == MODE_RR) rr_ptr <= sel + 2'd1;
                        state <= IDLE;
                    end
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
                    if (acc) begin
                        stall_cnt <= '0;
                    end else if (in_valid) begin
                        // Watchdog trip: the remainder of the packet
                        // is discarded and counted as a drop.
                        if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
                            stall_cnt <= '0;
                            stall_err <= 1'b1;
                            state     <= DROP;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
`endif
                end
                DROP: begin
                    if (acc && in_last) begin
                        drop_cnt <= drop_cnt + 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
Packet-level controller that sequences a demux_4to1_slice-style 1-to-4 datapath and shares it between four destination channels.
- Accepts a valid/ready input stream and selects a destination per packet, by address or round-robin.
- Drives the demux select and holds it stable for the whole packet.
- Gates per-channel valid/ready, drops packets aimed at disabled channels, and keeps per-channel packet counters.
- Sits in the ALU result-distribution path, between the result producer and the four consumers.

Parameters:
DATA_W, 8, width of in_data / out_data
CNT_W, 8, width of each packet counter and the drop counter
TIMEOUT, 16, stall-watchdog threshold in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = addressed (use in_dest), 1 = round-robin
en_mask  in  4  channel enable, bit k = channel k
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  DATA_W  beat payload
in_dest  in  2  destination channel; sampled on the first beat only
in_last  in  1  final beat of packet
sel  out  2  demux select; drives s[1:0] of the slice
out_data  out  DATA_W  payload to the demux data input; equals in_data
out_valid  out  4  per-channel valid
out_ready  in  4  per-channel ready
busy  out  1  state != IDLE
pkt_cnt  out  4*CNT_W  packets delivered per channel; channel k at bits [k*CNT_W +: CNT_W]
drop_cnt  out  CNT_W  packets dropped

Behaviour:
Reset (async, rst_n=0):
- state=IDLE, sel=0, rr_ptr=0, all counters 0.
- out_valid=0, in_ready=0, busy=0.

FSM states: IDLE, ROUTE, DROP.

IDLE:
- in_ready=0, out_valid=0.
- mode and en_mask are sampled only on the IDLE->ROUTE/DROP transition.
- On in_valid, a target is chosen:
  - Addressed mode: target=in_dest. If en_mask[in_dest]=1, set sel<=in_dest and go to ROUTE; otherwise go to DROP.
  - Round-robin mode: target = first enabled channel searching rr_ptr, rr_ptr+1, ... mod 4. If one is found, set sel<=target and go to ROUTE. If en_mask==0, go to DROP.
- Decision latency: 1 cycle, so no beat is accepted in the cycle in_valid first rises.

ROUTE:
- Pass-through: out_valid[sel]=in_valid, all other out_valid bits=0, in_ready=out_ready[sel].
- sel is held constant and is never combinationally derived from inputs.
- On an accepted beat with in_last=1:
  - pkt_cnt[sel]++ (wraps modulo 2^CNT_W).
  - In round-robin mode, rr_ptr<=sel+1 mod 4 (3 wraps to 0).
  - Go to IDLE.
- Minimum packet cost: single-beat packet = 2 cycles; N beats = N+1 cycles with ready held high.

DROP:
- in_ready=1, out_valid=0; beats are discarded.
- On an accepted in_last: drop_cnt++ (wraps) and go to IDLE. rr_ptr is unchanged.

Boundary conditions:
- in_valid drops mid-packet in ROUTE: state and sel are held; no timeout unless the optional feature is compiled in.
- en_mask changes mid-packet: no effect until the next IDLE decision.
- pkt_cnt at all-ones plus one delivery: wraps to 0.
- rst_n asserted mid-packet: immediate return to IDLE. The partial packet is neither counted nor dropped.

Optional Feature:
Macro: DEMUX_DISPATCH_TIMEOUT_EN
- Defined:
  - Adds output stall_err (1 bit, sticky, reset 0) and an internal stall counter.
  - The stall counter increments each ROUTE cycle with in_valid && !out_ready[sel], and clears on any accepted beat or on leaving ROUTE.
  - When the counter reaches TIMEOUT: set stall_err, force DROP for the rest of the packet (packet counted in drop_cnt, not pkt_cnt).
  - stall_err is cleared only by reset.
- Undefined: no stall_err port and no stall counter; ROUTE waits indefinitely.

Decomposition:
- Shared package demux_dispatch_pkg:
  - typedef enum logic [1:0] {IDLE, ROUTE, DROP} dispatch_state_t
  - typedef logic [1:0] chan_t
  - localparam NUM_CH = 4
  - localparam MODE_ADDR = 1'b0, MODE_RR = 1'b1
- One sub-module: rr_pick4. Combinational; inputs rr_ptr and en_mask; outputs target and found. Reused by other ALU-side arbiters.
- Counters and FSM stay in the top module.

Test Plan:
1. Reset then addressed mode, en_mask=4'hF, send 1-beat packets with in_dest=0,1,2,3 and out_ready=4'hF -> sel follows 0,1,2,3; out_valid=0001,0010,0100,1000; each pkt_cnt=1; every packet takes 2 cycles.
2. Round-robin mode, en_mask=4'b1011, six 1-beat packets -> sel sequence 0,1,3,0,1,3; pkt_cnt[2] stays 0.
3. Addressed mode, in_dest=2, en_mask=4'b1011, 3-beat packet -> in_ready=1 for 3 beats, out_valid=0, drop_cnt=1, busy falls after the last beat.
4. 4-beat packet to channel 1 with out_ready[1] low for 5 cycles mid-packet -> sel held at 1, in_ready=0 during the stall, all 4 beats delivered in order, pkt_cnt[1]=1.
5. Assert rst_n=0 during beat 2 of a packet -> next cycle state=IDLE, sel=0, all counters=0, out_valid=0.
6. With DEMUX_DISPATCH_TIMEOUT_EN, TIMEOUT=16, hold out_ready[0]=0 on a 2-beat packet -> stall_err=1 after 16 stalled cycles, rest of packet dropped, drop_cnt=1, pkt_cnt[0]=0.
